// File: rtl/syb_demapping.sv
// Receive-side ternary symbol demapper for 100BASE-T1: recovers rdn/sxn and runs
// the SILENT/HUNT/LOCKED tracker. Define SYB_DEMAP_ERRCNT_EN to build err_cnt.
module syb_demapping #(
    parameter int ZERO_RUN = 8,
    parameter int LOCK_CNT = 16,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       RAn,
    input  logic [1:0]       RBn,
    input  logic             rx_sd1,
    input  logic             rx_sxn,
    input  logic             err_clr,
    output logic [2:0]       rdn,
    output logic             rdn_vld,
    output logic             rsxn,
    output logic             rsxn_vld,
    output logic             rx_zero,
    output logic             rx_invalid,
    output logic             rx_lock,
    output logic             rx_silent,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int ZW = $clog2(ZERO_RUN + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        ST_SILENT = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t         state_r;
    logic [ZW-1:0]  zrun_r;
    logic [MW-1:0]  mcnt_r;

    logic [2:0]     rdn_s;
    logic           data_s;
    logic           sxv_s;
    logic           sx_s;
    logic           inv_s;
    logic           zero_s;
    logic           match_s;
    logic           mismatch_s;
    logic           zrun_hit_s;

    function automatic logic sym_is_invalid(input logic [1:0] sym);
        return (sym == 2'b10);
    endfunction

    // Combinational demap of the incoming ternary pair
    always_comb begin
        rdn_s  = 3'b000;
        data_s = 1'b0;
        sxv_s  = 1'b0;
        sx_s   = 1'b0;
        inv_s  = sym_is_invalid(RAn) || sym_is_invalid(RBn);
        zero_s = (!inv_s) && (RAn == 2'b00) && (RBn == 2'b00);
        case ({RAn, RBn})
            4'b0100: begin data_s = 1'b1; rdn_s = 3'b000; end
            4'b1100: begin data_s = 1'b1; rdn_s = 3'b100; end
            4'b0111: begin data_s = 1'b1; rdn_s = 3'b010; end
            4'b1101: begin data_s = 1'b1; rdn_s = 3'b110; end
            4'b0011: begin data_s = 1'b1; sxv_s = 1'b1; sx_s = 1'b0; rdn_s = {1'b0, rx_sd1, 1'b1}; end
            4'b0001: begin data_s = 1'b1; sxv_s = 1'b1; sx_s = 1'b0; rdn_s = {1'b1, rx_sd1, 1'b1}; end
            4'b1111: begin data_s = 1'b1; sxv_s = 1'b1; sx_s = 1'b1; rdn_s = {1'b0, rx_sd1, 1'b1}; end
            4'b0101: begin data_s = 1'b1; sxv_s = 1'b1; sx_s = 1'b1; rdn_s = {1'b1, rx_sd1, 1'b1}; end
            default: begin data_s = 1'b0; end
        endcase
    end

    // Scrambler-bit comparison and zero-run terminal detection
    always_comb begin
        match_s    = sxv_s && (sx_s == rx_sxn);
        mismatch_s = sxv_s && (sx_s != rx_sxn);
        zrun_hit_s = zero_s && (zrun_r == ZW'(ZERO_RUN - 1));
    end

    // Registered per-pair decode outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdn        <= 3'b000;
            rdn_vld    <= 1'b0;
            rsxn       <= 1'b0;
            rsxn_vld   <= 1'b0;
            rx_zero    <= 1'b0;
            rx_invalid <= 1'b0;
        end else begin
            rdn        <= rdn_s;
            rdn_vld    <= data_s;
            rsxn       <= sx_s;
            rsxn_vld   <= sxv_s;
            rx_zero    <= zero_s;
            rx_invalid <= inv_s;
        end
    end

    // Saturating run length of consecutive (0,0) pairs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zrun_r <= ZW'(0);
        end else if (zero_s) begin
            if (zrun_r != ZW'(ZERO_RUN)) begin
                zrun_r <= zrun_r + ZW'(1);
            end else begin
                zrun_r <= zrun_r;
            end
        end else begin
            zrun_r <= ZW'(0);
        end
    end

    // Lock/silence tracker; flags are updated alongside the state they mirror
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_SILENT;
            mcnt_r    <= MW'(0);
            rx_silent <= 1'b1;
            rx_lock   <= 1'b0;
        end else if (zrun_hit_s) begin
            state_r   <= ST_SILENT;
            mcnt_r    <= MW'(0);
            rx_silent <= 1'b1;
            rx_lock   <= 1'b0;
        end else begin
            case (state_r)
                ST_SILENT: begin
                    if (data_s) begin
                        state_r   <= ST_HUNT;
                        mcnt_r    <= MW'(0);
                        rx_silent <= 1'b0;
                        rx_lock   <= 1'b0;
                    end else begin
                        state_r   <= ST_SILENT;
                    end
                end
                ST_HUNT: begin
                    if (match_s) begin
                        if (mcnt_r == MW'(LOCK_CNT - 1)) begin
                            state_r <= ST_LOCKED;
                            mcnt_r  <= MW'(0);
                            rx_lock <= 1'b1;
                        end else begin
                            mcnt_r  <= mcnt_r + MW'(1);
                        end
                    end else if (mismatch_s || inv_s) begin
                        mcnt_r <= MW'(0);
                    end else begin
                        mcnt_r <= mcnt_r;
                    end
                end
                ST_LOCKED: begin
                    if (inv_s) begin
                        state_r <= ST_HUNT;
                        mcnt_r  <= MW'(0);
                        rx_lock <= 1'b0;
                    end else begin
                        state_r <= ST_LOCKED;
                    end
                end
                default: begin
                    state_r   <= ST_SILENT;
                    mcnt_r    <= MW'(0);
                    rx_silent <= 1'b1;
                    rx_lock   <= 1'b0;
                end
            endcase
        end
    end

`ifdef SYB_DEMAP_ERRCNT_EN
    logic [ERR_W-1:0] err_r;
    logic             err_inc_s;

    // Error events: invalid pairs while tracking, sxn mismatches while locked
    always_comb begin
        err_inc_s = (inv_s && (state_r != ST_SILENT)) ||
                    (mismatch_s && (state_r == ST_LOCKED));
    end

    // Saturating error counter; clear dominates increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= {ERR_W{1'b0}};
        end else if (err_clr) begin
            err_r <= {ERR_W{1'b0}};
        end else if (err_inc_s && (err_r != {ERR_W{1'b1}})) begin
            err_r <= err_r + {{(ERR_W-1){1'b0}}, 1'b1};
        end else begin
            err_r <= err_r;
        end
    end

    assign err_cnt = err_r;
`else
    logic unused_err_clr_s;
    assign unused_err_clr_s = err_clr;
    assign err_cnt          = {ERR_W{1'b0}};
`endif

endmodule

// File: tb/tb_syb_demapping.sv
// Directed bench for syb_demapping: decode table plus lock/silence/error sequences.
module tb_syb_demapping;

`ifdef SYB_DEMAP_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] RAn;
    logic [1:0] RBn;
    logic       rx_sd1;
    logic       rx_sxn;
    logic       err_clr;
    logic [2:0] rdn;
    logic       rdn_vld;
    logic       rsxn;
    logic       rsxn_vld;
    logic       rx_zero;
    logic       rx_invalid;
    logic       rx_lock;
    logic       rx_silent;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    syb_demapping #(.ZERO_RUN(8), .LOCK_CNT(16), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .RAn(RAn), .RBn(RBn), .rx_sd1(rx_sd1),
        .rx_sxn(rx_sxn), .err_clr(err_clr), .rdn(rdn), .rdn_vld(rdn_vld),
        .rsxn(rsxn), .rsxn_vld(rsxn_vld), .rx_zero(rx_zero),
        .rx_invalid(rx_invalid), .rx_lock(rx_lock), .rx_silent(rx_silent),
        .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic       sd1;
        logic [2:0] e_rdn;
        logic       e_vld;
        logic       e_sx;
        logic       e_sxv;
        logic       e_zero;
        logic       e_inv;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] e_err(input int v);
        return ERR_EN ? 32'(v) : 32'd0;
    endfunction

    task automatic apply(input logic [1:0] a, input logic [1:0] b, input logic sd, input logic sx, input logic clr);
        RAn = a; RBn = b; rx_sd1 = sd; rx_sxn = sx; err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        RAn = 2'b00; RBn = 2'b00; rx_sd1 = 1'b0; rx_sxn = 1'b0; err_clr = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("rst_rdn", 32'(rdn), 32'd0);
        chk("rst_flags", 32'({rdn_vld, rsxn, rsxn_vld, rx_zero, rx_invalid}), 32'd0);
        chk("rst_silent", 32'(rx_silent), 32'd1);
        chk("rst_lock", 32'(rx_lock), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic chk_state(input string name, input logic lock, input logic silent, input int err);
        chk({name, "_lock"}, 32'(rx_lock), 32'(lock));
        chk({name, "_silent"}, 32'(rx_silent), 32'(silent));
        chk({name, "_err"}, 32'(err_cnt), e_err(err));
    endtask

    initial begin
        vecs[0]  = '{2'b01, 2'b00, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2'b11, 2'b00, 1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{2'b01, 2'b11, 1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{2'b11, 2'b01, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{2'b00, 2'b11, 1'b1, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{2'b00, 2'b01, 1'b0, 3'b101, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{2'b11, 2'b11, 1'b1, 3'b011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{2'b01, 2'b01, 1'b0, 3'b101, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{2'b00, 2'b00, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{2'b10, 2'b00, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{2'b00, 2'b10, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{2'b10, 2'b10, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b1;
        #1;
        do_reset();

        // Zero pair from reset, then SILENT -> HUNT on data
        apply(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("zero_first", 32'(rx_zero), 32'd1);
        chk_state("zero_first", 1'b0, 1'b1, 0);
        apply(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("hunt_rdn0", 32'({rdn, rdn_vld, rsxn_vld}), 32'b000_1_0);
        chk_state("to_hunt", 1'b0, 1'b0, 0);
        apply(2'b11, 2'b01, 1'b0, 1'b0, 1'b0);
        chk("hunt_rdn1", 32'({rdn, rdn_vld, rsxn_vld}), 32'b110_1_0);

        // Decode table
        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].sd1, 1'b0, 1'b0);
            chk($sformatf("vec%0d_rdn", i), 32'(rdn), 32'(vecs[i].e_rdn));
            chk($sformatf("vec%0d_vld", i), 32'(rdn_vld), 32'(vecs[i].e_vld));
            chk($sformatf("vec%0d_sx", i), 32'(rsxn), 32'(vecs[i].e_sx));
            chk($sformatf("vec%0d_sxv", i), 32'(rsxn_vld), 32'(vecs[i].e_sxv));
            chk($sformatf("vec%0d_zero", i), 32'(rx_zero), 32'(vecs[i].e_zero));
            chk($sformatf("vec%0d_inv", i), 32'(rx_invalid), 32'(vecs[i].e_inv));
        end

        // Lock: 15 matches + mismatch does not lock; then 16 matches lock
        do_reset();
        apply(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) apply(2'b11, 2'b11, 1'b0, 1'b1, 1'b0);
        chk_state("m15", 1'b0, 1'b0, 0);
        apply(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
        chk_state("m15_mis", 1'b0, 1'b0, 0);
        for (int i = 0; i < 15; i++) apply(2'b11, 2'b11, 1'b0, 1'b1, 1'b0);
        chk_state("relock15", 1'b0, 1'b0, 0);
        apply(2'b11, 2'b11, 1'b0, 1'b1, 1'b0);
        chk_state("lock16", 1'b1, 1'b0, 0);

        // Invalid while locked, then clear together with another invalid
        apply(2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("lk_inv", 32'(rx_invalid), 32'd1);
        chk_state("lk_inv", 1'b0, 1'b0, 1);
        apply(2'b10, 2'b00, 1'b0, 1'b0, 1'b1);
        chk_state("clr_win", 1'b0, 1'b0, 0);

        // Relock, mismatch counts an error but keeps lock
        for (int i = 0; i < 16; i++) apply(2'b01, 2'b01, 1'b0, 1'b1, 1'b0);
        chk_state("relock", 1'b1, 1'b0, 0);
        apply(2'b00, 2'b11, 1'b0, 1'b1, 1'b0);
        chk_state("lk_mis", 1'b1, 1'b0, 1);

        // Zero run: 7 zeros keep lock, 8th goes silent
        for (int i = 0; i < 7; i++) apply(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        chk_state("zero7", 1'b1, 1'b0, 1);
        apply(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        chk_state("zero8", 1'b0, 1'b1, 1);
        apply(2'b10, 2'b01, 1'b0, 1'b0, 1'b0);
        chk_state("sil_inv", 1'b0, 1'b1, 1);

        // Interrupted zero run in HUNT does not silence
        apply(2'b11, 2'b00, 1'b0, 1'b0, 1'b1);
        chk_state("hunt2", 1'b0, 1'b0, 0);
        for (int i = 0; i < 7; i++) apply(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        apply(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) apply(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        chk_state("zrun_break", 1'b0, 1'b0, 0);

        // Saturation of err_cnt via invalid pairs in HUNT
        for (int i = 0; i < 254; i++) apply(2'b10, 2'b11, 1'b0, 1'b0, 1'b0);
        chk_state("err254", 1'b0, 1'b0, 254);
        apply(2'b10, 2'b11, 1'b0, 1'b0, 1'b0);
        chk_state("err255", 1'b0, 1'b0, 255);
        for (int i = 0; i < 3; i++) apply(2'b11, 2'b10, 1'b0, 1'b0, 1'b0);
        chk_state("err_sat", 1'b0, 1'b0, 255);

        // Asynchronous reset mid-stream, first pair after release decodes
        #2;
        do_reset();
        apply(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("post_rst_rdn", 32'({rdn, rdn_vld}), 32'b100_1);
        chk_state("post_rst", 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/syb_demapping.md
# syb_demapping

Receive-side ternary symbol demapper for the 100BASE-T1 PCS, the inverse of the transmit symbol mapper. It takes one ternary pair (RAn, RBn) per clock and recovers the 3-bit scrambled word rdn, using the local descrambler for the bit the line code does not carry. From pairs that carry the scrambler bit it also recovers sxn, and uses it to run a lock/silence state machine and an error counter for the PCS receive path.

## Interface
Parameters:
- ZERO_RUN, 8: consecutive (0,0) pairs that declare the link silent; must be ≥2.
- LOCK_CNT, 16: consecutive sxn matches needed to lock; must be ≥1.
- ERR_W, 8: width of err_cnt.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- RAn  in  2  pair-A symbol: 01=-1, 00=0, 11=+1, 10=invalid.
- RBn  in  2  pair-B symbol, same encoding as RAn.
- rx_sd1  in  1  local descrambler value of sdn[1]; used when the line pair does not carry it.
- rx_sxn  in  1  local expected sxn, aligned with the current pair.
- err_clr  in  1  synchronous clear of err_cnt.
- rdn  out  3  recovered word.
- rdn_vld  out  1  rdn is valid (data pair received).
- rsxn  out  1  recovered sxn.
- rsxn_vld  out  1  rsxn is meaningful.
- rx_zero  out  1  pair was (0,0).
- rx_invalid  out  1  either symbol was 10.
- rx_lock  out  1  FSM is in LOCKED.
- rx_silent  out  1  FSM is in SILENT.
- err_cnt  out  ERR_W  saturating error count.

## Operation
Demap table (A,B → rdn, rsxn/rsxn_vld):
- (-1,0)→000, (+1,0)→100, (-1,+1)→010, (+1,-1)→110; rsxn_vld=0.
- (0,+1)→0,rx_sd1,1 with rsxn=0; (0,-1)→1,rx_sd1,1 with rsxn=0.
- (+1,+1)→0,rx_sd1,1 with rsxn=1; (-1,-1)→1,rx_sd1,1 with rsxn=1.
- (0,0): rx_zero=1, rdn_vld=0, rdn=000.
- Any 10 code: rx_invalid=1, rdn_vld=0, rdn=000; takes priority over zero.
- rdn_vld=1 for all eight data pairs, regardless of FSM state.
- match means rsxn_vld and rsxn==rx_sxn; mismatch means rsxn_vld and rsxn!=rx_sxn.

zrun counter:
- Increments on a zero pair and saturates at ZERO_RUN.
- Clears on any non-zero pair, including an invalid one.

FSM (state SILENT/HUNT/LOCKED):
- SILENT: a valid data pair → HUNT with mcnt=0; zero or invalid pairs stay in SILENT.
- HUNT: a match increments mcnt; a mismatch or invalid pair clears mcnt. When mcnt would reach LOCK_CNT → LOCKED.
- LOCKED: an invalid pair → HUNT with mcnt=0; a mismatch only counts an error.
- Any state: the pair that brings zrun to ZERO_RUN → SILENT, with mcnt=0. This has priority over all other transitions.

err_cnt:
- +1 for each invalid pair outside SILENT.
- +1 for each mismatch in LOCKED.
- Saturates at all-ones.
- err_clr wins over an increment in the same cycle.

## Timing
- Reset values: rdn=000, all flags=0, rx_silent=1, rx_lock=0, err_cnt=0; state SILENT, zrun=0, mcnt=0.
- All outputs are registered. The pair sampled at edge N produces outputs after edge N (1-cycle latency).
- rx_sd1 and rx_sxn are sampled at the same edge as the pair.
- State flags reflect the state after the edge: the LOCK_CNT-th consecutive match asserts rx_lock at that same edge.
- Reset mid-stream returns to reset values immediately (asynchronous); the first pair after deassertion is decoded normally.
- There is no backpressure; one pair is accepted every clock.

## Configuration
- SYB_DEMAP_ERRCNT_EN defined: err_cnt logic is present as specified above.
- SYB_DEMAP_ERRCNT_EN undefined: err_cnt is tied to 0, err_clr is ignored, and no counter flops are built. All other behaviour is unchanged.

## Test plan
- Reset, then drive (00,00) → rdn=000, rx_silent=1, rx_lock=0, err_cnt=0.
- Drive (01,00) then (11,01), one per cycle → next cycles rdn=000 then 110, rdn_vld=1, rsxn_vld=0; state goes SILENT→HUNT.
- Drive (00,11) with rx_sd1=1 → rdn=011, rsxn=0, rsxn_vld=1. Then drive (01,01) with rx_sd1=0 → rdn=101, rsxn=1.
- From HUNT, drive 16 pairs of (11,11) with rx_sxn=1 → rx_lock rises after the 16th pair. A 15-match run followed by one mismatch does not lock.
- LOCKED, then one (10,00) → rx_invalid=1, err_cnt=1, state HUNT. Next, err_clr together with another invalid pair → err_cnt=0.
- LOCKED, then 7 zero pairs → still locked. The 8th zero pair → rx_silent=1, rx_lock=0. Also check err_cnt saturation at 255 with ERR_W=8.
